// File: rtl/offboard_frame_tx.sv
// -----------------------------------------------------------------------------
// offboard_frame_tx
//
// Framing stage that sits after the half-rate clock-domain crossing on the
// off-board link. Payload words arrive as a 32-bit valid/ready stream. Every
// FRAME_WORDS payload words are wrapped in a header word and a trailer word:
//   header  = {8'hA5, seq[7:0], 8'h00, FRAME_WORDS[7:0]}
//   trailer = {8'h5A, pad_cnt[7:0], csum[15:0]}
// If a frame is partially filled and the input then stays idle for
// FLUSH_TIMEOUT beats, the rest of the frame is filled with PAD_WORD.
// The block only advances on clk edges where half_clock is high (a "beat").
//
// Build option:
//   OFFBOARD_FRAME_CHECKSUM_EN  defined   -> the trailer carries a 16-bit
//                                            checksum of all payload/pad words
//                               undefined -> trailer[15:0] is 16'h0000
//
// Parameters:
//   FRAME_WORDS    payload words per frame (1..255)
//   FLUSH_TIMEOUT  idle beats before a partial frame is padded (0 = never)
//   PAD_WORD       value used for pad words
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   half_clock   beat qualifier from the half-rate divider
//   t0_data      payload word in
//   t0_valid     payload word valid
//   t0_ready     payload word accepted on this beat
//   i0_data      framed output word
//   i0_valid     framed output word valid
//   i0_ready     downstream ready
//   frame_count  number of frames whose trailer was accepted (wraps)
// -----------------------------------------------------------------------------
module offboard_frame_tx #(
  parameter int          FRAME_WORDS   = 8,
  parameter int          FLUSH_TIMEOUT = 64,
  parameter logic [31:0] PAD_WORD      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        half_clock,
  input  logic [31:0] t0_data,
  input  logic        t0_valid,
  output logic        t0_ready,
  output logic [31:0] i0_data,
  output logic        i0_valid,
  input  logic        i0_ready,
  output logic [15:0] frame_count
);

  localparam int               IDLE_W     = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_TIMEOUT);
  localparam logic [7:0]       LAST_IDX   = 8'(FRAME_WORDS - 1);
  localparam logic [7:0]       FW_BYTE    = 8'(FRAME_WORDS);
  localparam bit               TIMEOUT_EN = (FLUSH_TIMEOUT != 0);

  // S_TRAIL_ACK holds the loaded trailer until downstream takes it; the
  // end-of-frame bookkeeping happens only once the trailer really leaves.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_PAD,
    S_TRAILER,
    S_TRAIL_ACK
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [31:0]        i0_data_reg;
  logic               i0_valid_reg;
  logic [7:0]         seq_reg;
  logic [15:0]        frame_count_reg;
  logic [7:0]         pay_cnt_reg;
  logic [7:0]         pad_cnt_reg;
  logic [IDLE_W-1:0]  idle_cnt_reg;

  logic               beat;
  logic               slot_free;
  logic               in_xfer;
  logic               out_xfer;
  logic               pay_last;
  logic               timeout_hit;
  logic               idle_inc;

  logic               load_en;
  logic [31:0]        load_data;
  logic               cnt_inc;     // a payload or pad word is loaded
  logic               pad_inc;     // the loaded word is a pad word
  logic               frame_done;  // trailer accepted downstream
  logic [15:0]        csum_value;

  assign beat        = half_clock;
  assign slot_free   = !i0_valid_reg || i0_ready;
  assign out_xfer    = beat && i0_valid_reg && i0_ready;
  assign in_xfer     = beat && t0_valid && t0_ready;
  assign pay_last    = (pay_cnt_reg == LAST_IDX);
  assign timeout_hit = TIMEOUT_EN && (pay_cnt_reg != 8'd0) && (idle_cnt_reg == IDLE_MAX);

  // Idle beats only count once the frame has started; the counter stops at
  // the timeout value so it cannot wrap back below it.
  assign idle_inc = beat && (state_reg == S_PAYLOAD) && !t0_valid &&
                    (pay_cnt_reg != 8'd0) && (idle_cnt_reg != IDLE_MAX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (beat && t0_valid && slot_free) begin
          state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (in_xfer) begin
          if (pay_last) begin
            state_next = S_TRAILER;
          end
        end else if (beat && timeout_hit) begin
          state_next = S_PAD;
        end
      end
      S_PAD: begin
        if (beat && slot_free && pay_last) begin
          state_next = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (beat && slot_free) begin
          state_next = S_TRAIL_ACK;
        end
      end
      S_TRAIL_ACK: begin
        if (out_xfer) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    t0_ready   = 1'b0;
    load_en    = 1'b0;
    load_data  = 32'h0000_0000;
    cnt_inc    = 1'b0;
    pad_inc    = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // The header goes out first; the waiting payload word stays on t0.
        load_en   = beat && t0_valid && slot_free;
        load_data = {8'hA5, seq_reg, 8'h00, FW_BYTE};
      end
      S_PAYLOAD: begin
        t0_ready  = slot_free;
        load_en   = beat && t0_valid && slot_free;
        load_data = t0_data;
        cnt_inc   = beat && t0_valid && slot_free;
      end
      S_PAD: begin
        load_en   = beat && slot_free;
        load_data = PAD_WORD;
        cnt_inc   = beat && slot_free;
        pad_inc   = beat && slot_free;
      end
      S_TRAILER: begin
        load_en   = beat && slot_free;
        load_data = {8'h5A, pad_cnt_reg, csum_value};
      end
      S_TRAIL_ACK: begin
        frame_done = out_xfer;
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and frame counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      i0_valid_reg    <= 1'b0;
      i0_data_reg     <= 32'h0000_0000;
      seq_reg         <= 8'h00;
      frame_count_reg <= 16'h0000;
      pay_cnt_reg     <= 8'h00;
      pad_cnt_reg     <= 8'h00;
      idle_cnt_reg    <= '0;
    end else begin
      if (load_en) begin
        i0_valid_reg <= 1'b1;
        i0_data_reg  <= load_data;
      end else if (out_xfer) begin
        i0_valid_reg <= 1'b0;
      end

      if (frame_done) begin
        seq_reg         <= seq_reg + 8'd1;
        frame_count_reg <= frame_count_reg + 16'd1;
        pay_cnt_reg     <= 8'h00;
        pad_cnt_reg     <= 8'h00;
        idle_cnt_reg    <= '0;
      end else begin
        if (cnt_inc) begin
          pay_cnt_reg <= pay_cnt_reg + 8'd1;
        end
        if (pad_inc) begin
          pad_cnt_reg <= pad_cnt_reg + 8'd1;
        end
        if (in_xfer) begin
          idle_cnt_reg <= '0;
        end else if (idle_inc) begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checksum: 16-bit sum of both halves of every payload and pad word
  // ---------------------------------------------------------------------------
`ifdef OFFBOARD_FRAME_CHECKSUM_EN
  logic [15:0] csum_reg;
  logic [15:0] word_half [2];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_half
    assign word_half[gi] = load_data[gi*16 +: 16];
  end

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      csum_reg <= 16'h0000;
    end else if (cnt_inc) begin
      csum_reg <= csum_reg + word_half[1] + word_half[0];
    end
  end

  assign csum_value = csum_reg;
`else
  assign csum_value = 16'h0000;
`endif

  assign i0_data     = i0_data_reg;
  assign i0_valid    = i0_valid_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_offboard_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_offboard_frame_tx
//
// Directed testbench for offboard_frame_tx with FRAME_WORDS=4,
// FLUSH_TIMEOUT=4, PAD_WORD=0. Inputs change on the falling clk edge; a
// monitor records every output transfer shortly after the falling edge that
// precedes the beat on which it happens.
// -----------------------------------------------------------------------------
module tb_offboard_frame_tx;

`ifdef OFFBOARD_FRAME_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        half_clock = 1'b0;
  logic [31:0] t0_data    = 32'h0;
  logic        t0_valid   = 1'b0;
  logic        t0_ready;
  logic [31:0] i0_data;
  logic        i0_valid;
  logic        i0_ready   = 1'b1;
  logic [15:0] frame_count;

  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  int          out_beat[$];
  int          beat_no = 0;
  bit          log_en  = 1'b1;

  offboard_frame_tx #(
    .FRAME_WORDS  (4),
    .FLUSH_TIMEOUT(4),
    .PAD_WORD     (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .half_clock (half_clock),
    .t0_data    (t0_data),
    .t0_valid   (t0_valid),
    .t0_ready   (t0_ready),
    .i0_data    (i0_data),
    .i0_valid   (i0_valid),
    .i0_ready   (i0_ready),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) half_clock <= ~half_clock;

  // Output monitor: records the word that transfers on the coming beat.
  always @(negedge clk) begin
    #2;
    if (half_clock && !rst) begin
      beat_no++;
      if (i0_valid && i0_ready) begin
        out_q.push_back(i0_data);
        out_beat.push_back(beat_no);
        if (log_en) $display("xfer beat %0d data %08h", beat_no, i0_data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, got %0d compares, required run to finish", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Wait for the falling edge ahead of the next beat, drive the inputs for
  // that beat and report whether the payload word will be taken.
  task automatic beat_drive(input logic rdy, output bit acc);
    @(negedge clk);
    while (half_clock !== 1'b1) @(negedge clk);
    i0_ready = rdy;
    if (in_q.size() > 0) begin
      t0_valid = 1'b1;
      t0_data  = in_q[0];
    end else begin
      t0_valid = 1'b0;
      t0_data  = 32'h0;
    end
    #1;
    acc = t0_valid && t0_ready;
    if (acc) void'(in_q.pop_front());
  endtask

  task automatic pump_until(input int n_out, input int budget, output bit ok);
    bit acc;
    int b = 0;
    while (out_q.size() < n_out && b < budget) begin
      beat_drive(1'b1, acc);
      b++;
    end
    ok = (out_q.size() >= n_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    t0_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
    out_beat.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    t0_valid = 1'b1;
    t0_data = 32'h1234_5678;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (i0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_i0_valid: got %b want 0", i0_valid); end
    n_cmp++; if (i0_data !== 32'h0) begin n_fail++; $display("FAIL reset_i0_data: got %08h want 00000000", i0_data); end
    n_cmp++; if (t0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_t0_ready: got %b want 0", t0_ready); end
    n_cmp++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    @(negedge clk);
    rst = 1'b0;
    t0_valid = 1'b0;
    t0_data = 32'h0;
  endtask

  task automatic test_full_frame();
    logic [31:0] exp [6];
    bit ok;
    bit acc;
    int gap;
    exp = '{32'hA500_0004, 32'd1, 32'd2, 32'd3, 32'd4,
            (CSUM_EN ? 32'h5A00_000A : 32'h5A00_0000)};
    out_q.delete(); out_beat.delete();
    in_q = {32'd1, 32'd2, 32'd3, 32'd4};
    pump_until(6, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d words want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL full_word%0d: got %08h want %08h", i, out_q[i], exp[i]); end
    end
    gap = out_beat[5] - out_beat[0];
    n_cmp++; if (gap !== 5) begin n_fail++; $display("FAIL full_throughput: header-to-trailer got %0d beats want 5", gap); end
    beat_drive(1'b1, acc);
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL full_frame_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [6];
    bit ok;
    bit acc;
    int n_acc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    int b = 0;
    exp = '{32'hA501_0004, 32'd11, 32'd22, 32'd33, 32'd44,
            (CSUM_EN ? 32'h5A00_006E : 32'h5A00_0000)};
    out_q.delete(); out_beat.delete();
    in_q = {32'd11, 32'd22, 32'd33, 32'd44};
    while (out_q.size() < 6 && b < 60) begin
      if (stall_left > 0) begin
        beat_drive(1'b0, acc);
        n_cmp++; if (t0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_t0_ready: got %b want 0", t0_ready); end
        n_cmp++; if (i0_valid !== 1'b1 || i0_data !== 32'd22) begin
          n_fail++; $display("FAIL bp_hold: got valid %b data %08h want valid 1 data 00000016", i0_valid, i0_data);
        end
        stall_left--;
      end else begin
        beat_drive(1'b1, acc);
      end
      if (acc) n_acc++;
      if (n_acc == 2 && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      b++;
    end
    n_cmp++; if (out_q.size() < 6) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL bp_word%0d: got %08h want %08h", i, out_q[i], exp[i]); end
    end
    repeat (3) beat_drive(1'b1, acc);
    n_cmp++; if (out_q.size() !== 6) begin n_fail++; $display("FAIL bp_no_dup: got %0d words want 6", out_q.size()); end
    n_cmp++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL bp_frame_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_flush();
    logic [31:0] exp [6];
    bit ok;
    bit acc;
    int b = 0;
    int gap;
    exp = '{32'hA502_0004, 32'hDEAD_BEEF, 32'd7, 32'd0, 32'd0,
            (CSUM_EN ? 32'h5A02_9DA3 : 32'h5A02_0000)};
    out_q.delete(); out_beat.delete();
    in_q = {32'hDEAD_BEEF};
    while (in_q.size() > 0 && b < 20) begin
      beat_drive(1'b1, acc);
      b++;
    end
    // Three idle beats stay below the timeout; the next word must restart it.
    repeat (3) beat_drive(1'b1, acc);
    in_q.push_back(32'd7);
    pump_until(6, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL flush_timeout: got %0d words want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL flush_word%0d: got %08h want %08h", i, out_q[i], exp[i]); end
    end
    gap = out_beat[3] - out_beat[2];
    n_cmp++; if (gap < 5 || gap > 6) begin n_fail++; $display("FAIL flush_pad_delay: got %0d beats want 5..6", gap); end
    beat_drive(1'b1, acc);
    n_cmp++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL flush_frame_count: got %0d want 3", frame_count); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp [6];
    bit ok;
    bit acc;
    int b = 0;
    exp = '{32'hA500_0004, 32'd5, 32'd6, 32'd7, 32'd8,
            (CSUM_EN ? 32'h5A00_001A : 32'h5A00_0000)};
    out_q.delete(); out_beat.delete();
    in_q = {32'd1, 32'd2, 32'd3, 32'd4};
    while (in_q.size() > 2 && b < 20) begin
      beat_drive(1'b1, acc);
      b++;
    end
    @(negedge clk);
    rst = 1'b1;
    t0_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (i0_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", i0_valid); end
    n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_frame_count: got %0d want 0", frame_count); end
    @(negedge clk);
    rst = 1'b0;
    in_q.delete(); out_q.delete(); out_beat.delete();
    in_q = {32'd5, 32'd6, 32'd7, 32'd8};
    pump_until(6, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: got %0d words want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL mid_word%0d: got %08h want %08h", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    bit acc;
    logic [31:0] hdr;
    logic [7:0]  seq_b;
    do_reset();
    log_en = 1'b0;
    for (int f = 0; f < 258; f++) begin
      out_q.delete(); out_beat.delete();
      in_q = {32'(f), 32'(f + 1), 32'(f * 3), 32'hC0DE_0000};
      pump_until(6, 40, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout frame %0d: got %0d words want 6", f, out_q.size()); break; end
      if (f >= 254) begin
        seq_b = f[7:0];
        hdr = {8'hA5, seq_b, 8'h00, 8'h04};
        $display("frame %0d header %08h", f, out_q[0]);
        n_cmp++; if (out_q[0] !== hdr) begin n_fail++; $display("FAIL wrap_header frame %0d: got %08h want %08h", f, out_q[0], hdr); end
      end
      if (f == 256) begin
        beat_drive(1'b1, acc);
        n_cmp++; if (frame_count !== 16'd257) begin n_fail++; $display("FAIL wrap_frame_count: got %0d want 257", frame_count); end
      end
    end
    beat_drive(1'b1, acc);
    n_cmp++; if (frame_count !== 16'd258) begin n_fail++; $display("FAIL wrap_frame_count_end: got %0d want 258", frame_count); end
    log_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_flush();
    test_reset_midframe();
    test_seq_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
